// File: rtl/mem_ctrl_if.sv
// Request/response bus between the CPU side and the RAM sequencer.
// master = requester, slave = mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_word;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [15:0]       resp_rdata;

  modport master (
    output req_valid, req_we, req_word, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_word, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM request sequencer: byte/word reads and writes, one request in flight.
// Optional macro MEM_CTRL_ALIGN_CHECK_EN rejects word accesses at odd addresses.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | RAM read enable issued
// RD_WAIT | RAM data captured, result latched on exit
// WR_LO   | low byte (or only byte) written
// WR_HI   | high byte of a word written at A+1
// RESP    | response pulse, ready returns on exit
module mem_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_ctrl_if.slave         bus_if,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_n_o,
  output logic              mem_ena_o,
  output logic [7:0]        mem_din_o,
  input  logic [15:0]       mem_dout_i
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR_LO, WR_HI, RESP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [15:0]       resp_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_n_q;
  logic              ena_q;
  logic [7:0]        din_q;
  logic              word_q;
  logic [7:0]        wdata_hi_q;
  logic              reject_d;

  // A word at the last address would need a byte beyond the RAM.
`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign reject_d = bus_if.req_word &&
                    ((bus_if.req_addr == LAST_ADDR) || bus_if.req_addr[0]);
`else
  assign reject_d = bus_if.req_word && (bus_if.req_addr == LAST_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      we_n_q       <= 1'b1;
      ena_q        <= 1'b0;
      din_q        <= '0;
      word_q       <= 1'b0;
      wdata_hi_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_if.req_valid) begin
            ready_q    <= 1'b0;
            word_q     <= bus_if.req_word;
            wdata_hi_q <= bus_if.req_wdata[15:8];
            if (reject_d) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= RESP;
            end else begin
              ena_q   <= 1'b1;
              we_n_q  <= !bus_if.req_we;
              addr_q  <= bus_if.req_addr;
              din_q   <= bus_if.req_wdata[7:0];
              state_q <= bus_if.req_we ? WR_LO : RD;
            end
          end
        end
        RD: begin
          ena_q   <= 1'b0;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          resp_rdata_q <= word_q ? mem_dout_i : {8'h00, mem_dout_i[7:0]};
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          state_q      <= RESP;
        end
        WR_LO: begin
          if (word_q) begin
            addr_q  <= addr_q + ADDR_W'(1);
            din_q   <= wdata_hi_q;
            state_q <= WR_HI;
          end else begin
            ena_q        <= 1'b0;
            we_n_q       <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end
        end
        WR_HI: begin
          ena_q        <= 1'b0;
          we_n_q       <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          state_q      <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.req_ready  = ready_q;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_err   = resp_err_q;
  assign bus_if.resp_rdata = resp_rdata_q;
  assign mem_addr_o        = addr_q;
  assign mem_we_n_o        = we_n_q;
  assign mem_ena_o         = ena_q;
  assign mem_din_o         = din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-array reference model, per-cycle compare
// of handshake, RAM enable window and responses, directed plus random requests.
module tb_mem_ctrl;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] mem_addr;
  logic        mem_we_n;
  logic        mem_ena;
  logic [7:0]  mem_din;
  logic [15:0] mem_dout = '0;

  mem_ctrl_if #(.ADDR_W(11)) bus ();

  mem_ctrl #(.ADDR_W(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_if     (bus),
    .mem_addr_o (mem_addr),
    .mem_we_n_o (mem_we_n),
    .mem_ena_o  (mem_ena),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM environment: registered read of {byte[A+1], byte[A]}
  logic [7:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_ena) begin
      if (!mem_we_n) ram[mem_addr] <= mem_din;
      else           mem_dout <= {ram[mem_addr + 11'd1], ram[mem_addr]};
    end
  end

  typedef struct {
    int          edge_n;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:2047];
  logic [15:0] last_rdata = '0;
  logic [15:0] seen_rdata = '0;
  bit          seen_err = 1'b0;
  int          cyc = 0;
  int          busy_lo = 1, busy_hi = 0;
  int          ena_lo = 1, ena_hi = 0;
  int          last_acc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model's windows and expected responses
  always @(negedge clk) begin
    exp_t e;
    #2;
    chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !(cyc >= busy_lo && cyc <= busy_hi)});
    chk("mem_ena", {31'd0, mem_ena}, {31'd0, (cyc >= ena_lo && cyc <= ena_hi)});
    if (bus.resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.edge_n);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        chk("resp_rdata", {16'd0, bus.resp_rdata}, {16'd0, e.rdata});
        seen_rdata = bus.resp_rdata;
        seen_err   = bus.resp_err;
      end
    end else if (q.size() > 0 && cyc > q[0].edge_n) begin
      chk("missing_resp", 32'd0, 32'd1);
      void'(q.pop_front());
    end
  end

  task automatic issue(bit we, bit word, logic [10:0] a, logic [15:0] wd);
    int   acc, off;
    bit   rej, got;
    exp_t e;
    logic [10:0] a1;
    a1 = a + 11'd1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_word  = word;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    last_acc = acc;
    rej = word && (a == 11'h7FF || (ALIGN && a[0]));
    if (rej)     off = 0;
    else if (we) off = word ? 2 : 1;
    else         off = 2;
    busy_lo = acc;
    busy_hi = acc + off;
    ena_lo  = acc;
    ena_hi  = rej ? acc - 1 : acc + ((we && word) ? 1 : 0);
    if (!rej) begin
      if (we) begin
        ref_mem[a] = wd[7:0];
        if (word) ref_mem[a1] = wd[15:8];
      end else begin
        last_rdata = word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
      end
    end
    e.edge_n = acc + off;
    e.err    = rej;
    e.rdata  = last_rdata;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    #3;
    if (q.size() > 0) begin
      chk("done_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    q.delete();
    busy_lo = 1; busy_hi = 0;
    ena_lo  = 1; ena_hi  = 0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  saved;
    int          a0, pick;
    logic [10:0] ra;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_word  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #1;
    do_reset();
    #3;
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", {16'd0, bus.resp_rdata}, 32'd0);
    chk("rst_mem_we_n", {31'd0, mem_we_n}, 32'd1);
    chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);

    // Reset after E1 of a word write: only the low byte lands
    saved = ref_mem[11'h011];
    issue(1'b1, 1'b1, 11'h010, 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    ref_mem[11'h011] = saved;
    #3;
    chk("rst_mid_ena", {31'd0, mem_ena}, 32'd0);
    issue(1'b0, 1'b0, 11'h010, 16'h0);  idle(); wait_done();
    chk("lit_rd_010", {16'd0, seen_rdata}, 32'h0000_00EF);
    issue(1'b0, 1'b0, 11'h011, 16'h0);  idle(); wait_done();
    chk("lit_rd_011", {16'd0, seen_rdata}, 32'h0000_0000);

    issue(1'b1, 1'b1, 11'h100, 16'hA55A); idle(); wait_done();
    issue(1'b0, 1'b1, 11'h100, 16'h0);    idle(); wait_done();
    chk("lit_rd_100", {16'd0, seen_rdata}, 32'h0000_A55A);

    issue(1'b1, 1'b1, 11'h200, 16'h1122); idle(); wait_done();
    issue(1'b1, 1'b0, 11'h201, 16'hFF3C); idle(); wait_done();
    issue(1'b0, 1'b1, 11'h200, 16'h0);    idle(); wait_done();
    chk("lit_rd_200", {16'd0, seen_rdata}, 32'h0000_3C22);
    issue(1'b0, 1'b0, 11'h201, 16'h0);    idle(); wait_done();
    chk("lit_rd_201", {16'd0, seen_rdata}, 32'h0000_003C);

    issue(1'b1, 1'b1, 11'h7FF, 16'h1234); idle(); wait_done();
    chk("lit_err_7ff", {31'd0, seen_err}, 32'd1);
    issue(1'b1, 1'b0, 11'h7FF, 16'h0077); idle(); wait_done();
    issue(1'b0, 1'b0, 11'h7FF, 16'h0);    idle(); wait_done();
    chk("lit_rd_7ff", {16'd0, seen_rdata}, 32'h0000_0077);
    chk("lit_err_clr", {31'd0, seen_err}, 32'd0);

    issue(1'b0, 1'b1, 11'h0FF, 16'h0);    idle(); wait_done();
    if (ALIGN) chk("lit_unaligned_err", {31'd0, seen_err}, 32'd1);
    else       chk("lit_unaligned_rd", {16'd0, seen_rdata}, 32'h0000_5A00);

    // Valid held high across four word reads
    issue(1'b0, 1'b1, 11'h100, 16'h0); a0 = last_acc;
    issue(1'b0, 1'b1, 11'h200, 16'h0); chk("b2b_gap1", last_acc - a0, 32'd4); a0 = last_acc;
    issue(1'b0, 1'b1, 11'h100, 16'h0); chk("b2b_gap2", last_acc - a0, 32'd4); a0 = last_acc;
    issue(1'b0, 1'b1, 11'h200, 16'h0); chk("b2b_gap3", last_acc - a0, 32'd4);
    idle(); wait_done();
    chk("b2b_last", {16'd0, seen_rdata}, 32'h0000_3C22);

    repeat (60) begin
      pick = $urandom_range(0, 3);
      ra = (pick == 0) ? 11'(11'h7FF - 11'($urandom_range(0, 2)))
                       : 11'(11'h0F8 + 11'($urandom_range(0, 15)));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Request sequencer that sits directly upstream of the byte-wide RAM block: accepts byte/word read and write requests from the CPU/bus side over a valid/ready handshake, and drives the RAM's addr/we_n/ena/din.
- Splits a 16-bit write into two byte writes (low byte at A, high byte at A+1).
- Captures the RAM's registered 16-bit read data and returns it with a one-cycle response pulse.
- One request in flight at a time; no pipelining.

Parameters:
- ADDR_W, 11, RAM byte-address width; the last valid byte address is 2^ADDR_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted on an edge where req_valid&req_ready
- req_we  in  1  1=write, 0=read
- req_word  in  1  1=16-bit access, 0=8-bit access
- req_addr  in  ADDR_W  byte address
- req_wdata  in  16  write data; only [7:0] is used for byte writes
- resp_valid  out  1  one-cycle pulse: read data valid / write done / error
- resp_err  out  1  qualified by resp_valid; access rejected
- resp_rdata  out  16  read data; byte read is zero-extended
- mem_addr  out  ADDR_W  to RAM addr
- mem_we_n  out  1  to RAM we_n (0=write)
- mem_ena  out  1  to RAM ena
- mem_din  out  8  to RAM din
- mem_dout  in  16  from RAM dout; {byte[A+1], byte[A]}, valid the cycle after a read enable

Behaviour:
- Reset values (immediate, async):
  - state=IDLE
  - req_ready=1
  - resp_valid=0, resp_err=0, resp_rdata=0
  - mem_ena=0, mem_we_n=1, mem_addr=0, mem_din=0
- All RAM-side outputs are registered.
- req_ready = (state==IDLE). Request fields are latched only at the accept edge E0. Inputs are ignored outside IDLE.
- States: IDLE, RD, RD_WAIT, WR_LO, WR_HI, RESP.
- Read (byte or word):
  - E0 -> RD: mem_ena=1, mem_we_n=1, mem_addr=A.
  - E1 -> RD_WAIT: mem_ena=0. The RAM captures data at E1.
  - E2 -> RESP: resp_rdata = word ? mem_dout : {8'h00, mem_dout[7:0]}; resp_valid=1.
  - E3 -> IDLE.
  - Read latency: resp_valid is high in the 3rd cycle after the accept edge.
- Write byte:
  - E0 -> WR_LO: ena=1, we_n=0, addr=A, din=wdata[7:0].
  - E1 -> RESP: ena=0, we_n=1; resp_valid=1.
  - E2 -> IDLE.
- Write word:
  - E0 -> WR_LO (as for byte write).
  - E1 -> WR_HI: addr=A+1, din=wdata[15:8].
  - E2 -> RESP: ena=0, we_n=1; resp_valid=1.
  - E3 -> IDLE.
- resp_rdata is unchanged by writes and holds its last value between responses. resp_err is cleared on every non-error response.
- Boundary:
  - Word access (read or write) with A == 2^ADDR_W-1 is rejected: E0 -> RESP with resp_err=1, no RAM enable, resp_rdata unchanged.
  - Byte access at the last address is legal.
  - mem_ena is never asserted in IDLE or RESP.
- Reset mid-operation: the state machine aborts and mem_ena drops immediately. A word write interrupted after E1 leaves the low byte written and the high byte untouched. No response is issued.
- req_valid held high in RESP: not accepted until the IDLE cycle that follows. Back-to-back throughput is 1 request per 4 cycles (read/word write) or 3 cycles (byte write).

Optional Feature:
- Macro: MEM_CTRL_ALIGN_CHECK_EN.
- Defined: a word access to an odd address (req_addr[0]==1) is also rejected exactly like the last-address case (E0 -> RESP, resp_err=1, no RAM access).
- Undefined: unaligned word accesses are legal and performed as bytes A and A+1. Only the last-address rule produces resp_err.

Test Plan:
- Reset asserted mid word write (after E1, addr 0x010, data 0xBEEF); release; byte read 0x010 -> 0x00EF; byte read 0x011 -> previous contents (0x00).
- Word write 0xA55A @0x100, then word read @0x100 -> resp_rdata=0xA55A, resp_valid exactly 1 cycle, 3rd cycle after accept; mem_ena high exactly 1 cycle during the read.
- Byte write 0x3C @0x201 over word 0x1122 @0x200, then word read @0x200 -> 0x3C22; byte read @0x201 -> 0x003C.
- Word write @0x7FF -> resp_err=1 in cycle after accept, mem_ena never asserted; byte write 0x77 @0x7FF then byte read -> 0x0077, resp_err=0.
- Word read @0x0FF -> with MEM_CTRL_ALIGN_CHECK_EN resp_err=1 and no RAM access; without it resp_rdata = {byte[0x100], byte[0x0FF]}.
- req_valid held high continuously with 4 word reads queued -> req_ready low during RD/RD_WAIT/RESP, one accept every 4 cycles, exactly 4 resp_valid pulses, no data corruption.
